sponge_padder: RTL

Parametrised Keccak sponge padder. It accepts a message as a stream of 32-bit words and emits rate-sized padded blocks to the f-permutation stage. Rate is set by a parameter, and domain separation is selected per message, covering Keccak, SHA3 and SHAKE. It replaces the fixed-rate, fixed-suffix padders in the hash path, so a single block serves SHA3-256/512 and SHAKE128/256 for Kyber.

---
 rtl/keccak_pkg.sv | 41 ++++
 rtl/pad_word_gen.sv | 23 ++
 rtl/sponge_padder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak/SHA3/SHAKE constants, mode encoding and padder state type
package keccak_pkg;

  // Domain-separation suffix bytes
  localparam logic [7:0] KECCAK_SFX = 8'h01;
  localparam logic [7:0] SHA3_SFX   = 8'h06;
  localparam logic [7:0] SHAKE_SFX  = 8'h1F;

  // Per-message suffix selection
  typedef enum logic [1:0] {
    MODE_KECCAK = 2'd0,
    MODE_SHA3   = 2'd1,
    MODE_SHAKE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // Rates in 32-bit words for the Kyber hash instances
  localparam int SHA3_256_RATE = 34;
  localparam int SHA3_512_RATE = 18;
  localparam int SHAKE128_RATE = 42;
  localparam int SHAKE256_RATE = 34;

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_FULL   = 2'd2,
    ST_DONE   = 2'd3
  } pad_state_t;

  // Reserved mode falls back to the SHA3 suffix
  function automatic logic [7:0] mode_suffix(input logic [1:0] mode);
    logic [7:0] sfx;
    case (mode)
      MODE_KECCAK: sfx = KECCAK_SFX;
      MODE_SHAKE:  sfx = SHAKE_SFX;
      default:     sfx = SHA3_SFX;
    endcase
    return sfx;
  endfunction

endpackage

// File: rtl/pad_word_gen.sv
// rtl/pad_word_gen.sv - builds one 32-bit word: passthrough, or message bytes + suffix + zero fill
module pad_word_gen (
  input  logic [31:0] in,
  input  logic [1:0]  byte_num,
  input  logic [7:0]  suffix,
  input  logic        last_flag,
  output logic [31:0] word
);

  // Keep the leading byte_num bytes, place the suffix right after them, zero the rest
  always_comb begin
    word = in;
    if (last_flag) begin
      case (byte_num)
        2'd0:    word = {suffix, 24'h000000};
        2'd1:    word = {in[31:24], suffix, 16'h0000};
        2'd2:    word = {in[31:16], suffix, 8'h00};
        default: word = {in[31:8], suffix};
      endcase
    end
  end

endmodule

// File: rtl/sponge_padder.sv
// rtl/sponge_padder.sv - parametrised Keccak sponge padder producing rate-sized blocks
module sponge_padder
  import keccak_pkg::*;
#(
  parameter int RATE_WORDS = 34
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [1:0]                mode,
  input  logic [31:0]               in,
  input  logic                      in_ready,
  input  logic                      is_last,
  input  logic [1:0]                byte_num,
  output logic                      buffer_full,
  output logic [32*RATE_WORDS-1:0]  out,
  output logic                      out_ready,
  input  logic                      f_ack,
  output logic                      msg_done
);

  localparam int         W        = 32 * RATE_WORDS;
  localparam logic [5:0] LAST_CNT = 6'(RATE_WORDS - 1);

  pad_state_t  state;
  logic [5:0]  cnt;
  logic [7:0]  msg_sfx;
  logic        msg_started;
  logic        sfx_in_block;

  logic [7:0]  cur_sfx;
  logic [31:0] gen_in;
  logic [1:0]  gen_bn;
  logic [7:0]  gen_sfx;
  logic        gen_last;
  logic [31:0] pad_word;
  logic [31:0] next_word;
  logic        final_slot;

  // Mode only counts on the first word of a message; later words reuse the latched suffix
  assign cur_sfx = msg_started ? msg_sfx : mode_suffix(mode);

  // PAD reuses the generator with an all-zero last word so both paths share one datapath
  always_comb begin
    gen_in   = in;
    gen_bn   = byte_num;
    gen_sfx  = cur_sfx;
    gen_last = is_last;
    if (state == ST_PAD) begin
      gen_in   = 32'h0;
      gen_bn   = 2'd0;
      gen_sfx  = 8'h00;
      gen_last = 1'b1;
    end
  end

  pad_word_gen u_pad_word_gen (
    .in        (gen_in),
    .byte_num  (gen_bn),
    .suffix    (gen_sfx),
    .last_flag (gen_last),
    .word      (pad_word)
  );

  // The closing 0x80 bit goes into the last rate word once the suffix has been placed
  assign final_slot = (cnt == LAST_CNT) && ((state == ST_PAD) || is_last);
  assign next_word  = pad_word | (final_slot ? 32'h00000080 : 32'h00000000);

  // Padder FSM, shift register and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ABSORB;
      cnt          <= 6'd0;
      out          <= '0;
      msg_sfx      <= 8'h00;
      msg_started  <= 1'b0;
      sfx_in_block <= 1'b0;
      out_ready    <= 1'b0;
      buffer_full  <= 1'b0;
      msg_done     <= 1'b0;
    end else if (clear) begin
      state        <= ST_ABSORB;
      cnt          <= 6'd0;
      out          <= '0;
      msg_sfx      <= 8'h00;
      msg_started  <= 1'b0;
      sfx_in_block <= 1'b0;
      out_ready    <= 1'b0;
      buffer_full  <= 1'b0;
      msg_done     <= 1'b0;
    end else begin
      case (state)
        ST_ABSORB: begin
          if (in_ready) begin
            out <= {out[W-33:0], next_word};
            cnt <= cnt + 6'd1;
            if (!msg_started) begin
              msg_started <= 1'b1;
              msg_sfx     <= mode_suffix(mode);
            end
            if (is_last) begin
              sfx_in_block <= 1'b1;
            end
            if (cnt == LAST_CNT) begin
              state       <= ST_FULL;
              out_ready   <= 1'b1;
              buffer_full <= 1'b1;
            end else if (is_last) begin
              state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          out <= {out[W-33:0], next_word};
          cnt <= cnt + 6'd1;
          if (cnt == LAST_CNT) begin
            state       <= ST_FULL;
            out_ready   <= 1'b1;
            buffer_full <= 1'b1;
          end
        end
        ST_FULL: begin
          if (f_ack) begin
            cnt         <= 6'd0;
            out_ready   <= 1'b0;
            buffer_full <= 1'b0;
            if (sfx_in_block) begin
              state    <= ST_DONE;
              msg_done <= 1'b1;
            end else begin
              state <= ST_ABSORB;
            end
          end
        end
        ST_DONE: begin
          msg_done <= 1'b1;
        end
        default: begin
          state <= ST_ABSORB;
        end
      endcase
    end
  end

endmodule
